z80_mem_ctrl: RTL and testbench
===============================

Z80_MEM_CTRL -- requirements
Module: z80_mem_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: memory wait states inserted before the SRAM access, legal range 0..15.
REQ-002 SHALL have parameter IO_BASE, default 8'h00: I/O port address decoded on ADDR[7:0].
REQ-003 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port ADDR, input, 16: CPU address bus.
REQ-006 SHALL have port DO, input, 8: CPU write data.
REQ-007 SHALL have port DI, output, 8: read data returned to the CPU.
REQ-008 SHALL have ports WR, MREQ, IORQ and M1, each input, 1: active-high core-side CPU strobes.
REQ-009 SHALL have port WAIT, output, 1: active-high CPU stall request.
REQ-010 SHALL have port SRAM_ADDR, output, 16: SRAM address.
REQ-011 SHALL have port SRAM_WDATA, output, 8: SRAM write data.
REQ-012 SHALL have port SRAM_RDATA, input, 8: SRAM read data, valid in the cycle after SRAM_CS.
REQ-013 SHALL have ports SRAM_CS and SRAM_WE, each output, 1: active-high SRAM chip select and write enable.
REQ-014 SHALL have port IO_IN, input, 8: external input port.
REQ-015 SHALL have port IO_OUT, output, 8: registered output port.
REQ-016 SHALL have port INT_VEC, input, 8: vector returned on interrupt acknowledge.

Function
REQ-017 SHALL implement FSM states IDLE, WAITST, ACCESS, IOCYC, DONE; every output SHALL be registered.
REQ-018 SHALL register MREQ and IORQ each cycle and detect a new cycle as strobe=1 while its registered copy=0.
REQ-019 On a new cycle, SHALL latch ADDR, DO and WR into internal registers.
REQ-020 Memory cycle in IDLE: if WAIT_CYCLES>0, go to WAITST with counter=WAIT_CYCLES-1; else go to ACCESS; WAIT=1 from the next cycle.
REQ-021 WAITST SHALL decrement the counter each cycle and go to ACCESS when the counter is 0, so WAITST lasts exactly WAIT_CYCLES cycles.
REQ-022 ACCESS SHALL last one cycle with SRAM_CS=1, SRAM_WE=latched WR, SRAM_ADDR=latched ADDR and SRAM_WDATA=latched DO.
REQ-023 On entry to DONE after a read, DI SHALL capture SRAM_RDATA; WAIT SHALL be 0 in DONE.
REQ-024 WAIT SHALL be 1 for exactly WAIT_CYCLES+1 cycles per memory cycle.
REQ-025 I/O cycle (IORQ, M1=0) in IDLE SHALL go to IOCYC for one cycle with WAIT=1, then go to DONE.
REQ-026 In IOCYC with latched ADDR[7:0]==IO_BASE, a write SHALL load IO_OUT=latched DO and a read SHALL set DI=IO_IN.
REQ-027 In IOCYC with an unmatched address, a write SHALL be ignored and a read SHALL set DI=8'hFF.
REQ-028 Interrupt acknowledge (IORQ and M1) SHALL go to IOCYC and set DI=INT_VEC; IO_OUT SHALL be unchanged.
REQ-029 When MREQ and IORQ rise in the same cycle, MREQ SHALL take priority and IORQ SHALL be ignored until both return to 0.
REQ-030 DONE SHALL hold DI and return to IDLE only when MREQ=0 and IORQ=0.
REQ-031 A strobe dropping before DONE SHALL NOT abort the cycle; the FSM SHALL complete it.
REQ-032 New-cycle detection SHALL be ignored in every state except IDLE.

Reset
REQ-033 While RESET=0, the FSM SHALL be in IDLE with counter=0 and WAIT, SRAM_CS and SRAM_WE at 0.
REQ-034 While RESET=0, SRAM_ADDR=16'h0000, SRAM_WDATA=8'h00, DI=8'hFF, IO_OUT=8'h00, and the registered strobe copies SHALL be 0.
REQ-035 Reset asserted mid-cycle SHALL abandon the cycle immediately and drop WAIT and SRAM_CS asynchronously.
REQ-036 After reset release, a strobe already held high SHALL be treated as a new cycle.

Structure
REQ-037 FSM state encoding and the IDLE/DONE default values of DI SHALL live in the shared package z80_pkg.
REQ-038 The wait-state counter SHALL be the sub-module z80_wait_cnt (load, decrement, zero flag).
REQ-039 The block SHALL instantiate between cpu_z80 outputs and pad/SRAM inputs, driving cpu_z80 WAIT and DI.

Verification
REQ-040 Memory read, WAIT_CYCLES=2, ADDR=16'h1234, SRAM_RDATA=8'hA5 -> WAIT high 3 cycles, one SRAM_CS pulse with WE=0 at SRAM_ADDR 16'h1234, DI=8'hA5 in DONE.
REQ-041 Memory write, WAIT_CYCLES=0, ADDR=16'hFFFF, DO=8'h3C -> WAIT high 1 cycle, SRAM_CS=SRAM_WE=1 for 1 cycle, SRAM_WDATA=8'h3C.
REQ-042 I/O write at ADDR[7:0]=IO_BASE with DO=8'h81, then I/O read at 8'h55 -> IO_OUT=8'h81, read returns DI=8'hFF.
REQ-043 IORQ and M1 with INT_VEC=8'hE7 -> one WAIT cycle, DI=8'hE7, IO_OUT unchanged.
REQ-044 MREQ and IORQ rising together -> memory cycle only, no IOCYC entry.
REQ-045 RESET low during WAITST -> WAIT=0 and IDLE immediately; a fresh read completes correctly after release.

Source files
------------

// File: rtl/z80_pkg.sv
// rtl/z80_pkg.sv - shared state encoding and DI default values for the Z80 memory controller
package z80_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAITST = 3'd1,
      ST_ACCESS = 3'd2,
      ST_IOCYC  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam int         WAIT_CNT_W  = 4;
   localparam logic [7:0] DI_IDLE     = 8'hFF;
   localparam logic [7:0] DI_UNMAPPED = 8'hFF;

endpackage

// File: rtl/z80_wait_cnt.sv
// rtl/z80_wait_cnt.sv - loadable down-counter that times memory wait states
module z80_wait_cnt
   import z80_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [WAIT_CNT_W-1:0] load_val,
   input  logic                  dec,
   output logic                  zero
);

   logic [WAIT_CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && cnt != '0)
         cnt <= cnt - WAIT_CNT_W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/z80_mem_ctrl.sv
// rtl/z80_mem_ctrl.sv - Z80 bus cycle controller: wait-stated SRAM access, one I/O port, INTA vector
module z80_mem_ctrl
   import z80_pkg::*;
#(
   parameter int         WAIT_CYCLES = 2,
   parameter logic [7:0] IO_BASE     = 8'h00
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] ADDR,
   input  logic [7:0]  DO,
   output logic [7:0]  DI,
   input  logic        WR,
   input  logic        MREQ,
   input  logic        IORQ,
   input  logic        M1,
   output logic        WAIT,
   output logic [15:0] SRAM_ADDR,
   output logic [7:0]  SRAM_WDATA,
   input  logic [7:0]  SRAM_RDATA,
   output logic        SRAM_CS,
   output logic        SRAM_WE,
   input  logic [7:0]  IO_IN,
   output logic [7:0]  IO_OUT,
   input  logic [7:0]  INT_VEC
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

   state_t      state_q, state_d;
   logic        mreq_q, iorq_q;
   logic [15:0] addr_l;
   logic [7:0]  do_l;
   logic        wr_l, m1_l;
   logic        rd_cap_q, rd_cap_d;
   logic        latch_en, cnt_load, cnt_dec, cnt_zero;
   logic        wait_d, cs_d, we_d;
   logic [7:0]  di_d, io_out_d;
   logic        new_mem, new_io;
   logic [15:0] cur_addr;
   logic [7:0]  cur_do;
   logic        cur_wr;

   z80_wait_cnt u_wait_cnt (
      .clk      (CLK),
      .rst_n    (RESET),
      .load     (cnt_load),
      .load_val (WAIT_LOAD),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // MREQ wins a simultaneous rise; the ignored IORQ is masked by DONE waiting for both low.
   assign new_mem = MREQ & ~mreq_q;
   assign new_io  = IORQ & ~iorq_q & ~new_mem;

   // Zero-wait accesses leave IDLE straight into ACCESS before the latches are loaded.
   assign cur_addr = (state_q == ST_IDLE) ? ADDR : addr_l;
   assign cur_do   = (state_q == ST_IDLE) ? DO   : do_l;
   assign cur_wr   = (state_q == ST_IDLE) ? WR   : wr_l;

   always_comb begin
      state_d  = state_q;
      latch_en = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      wait_d   = 1'b0;
      cs_d     = 1'b0;
      we_d     = 1'b0;
      di_d     = DI;
      io_out_d = IO_OUT;
      rd_cap_d = rd_cap_q;
      case (state_q)
         ST_IDLE: begin
            if (new_mem) begin
               latch_en = 1'b1;
               wait_d   = 1'b1;
               if (WAIT_CYCLES > 0) begin
                  state_d  = ST_WAITST;
                  cnt_load = 1'b1;
               end else begin
                  state_d = ST_ACCESS;
                  cs_d    = 1'b1;
                  we_d    = cur_wr;
               end
            end else if (new_io) begin
               latch_en = 1'b1;
               wait_d   = 1'b1;
               state_d  = ST_IOCYC;
            end
         end
         ST_WAITST: begin
            wait_d = 1'b1;
            if (cnt_zero) begin
               state_d = ST_ACCESS;
               cs_d    = 1'b1;
               we_d    = cur_wr;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_ACCESS: begin
            state_d  = ST_DONE;
            rd_cap_d = ~wr_l;
         end
         ST_IOCYC: begin
            state_d = ST_DONE;
            if (m1_l)
               di_d = INT_VEC;
            else if (addr_l[7:0] == IO_BASE) begin
               if (wr_l)
                  io_out_d = do_l;
               else
                  di_d = IO_IN;
            end else if (!wr_l)
               di_d = DI_UNMAPPED;
         end
         ST_DONE: begin
            // SRAM data arrives the cycle after the chip select, so capture before leaving.
            if (rd_cap_q) begin
               di_d     = SRAM_RDATA;
               rd_cap_d = 1'b0;
            end else if (!MREQ && !IORQ) begin
               state_d = ST_IDLE;
               di_d    = DI_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= ST_IDLE;
         mreq_q     <= 1'b0;
         iorq_q     <= 1'b0;
         addr_l     <= '0;
         do_l       <= '0;
         wr_l       <= 1'b0;
         m1_l       <= 1'b0;
         rd_cap_q   <= 1'b0;
         WAIT       <= 1'b0;
         SRAM_CS    <= 1'b0;
         SRAM_WE    <= 1'b0;
         SRAM_ADDR  <= 16'h0000;
         SRAM_WDATA <= 8'h00;
         DI         <= DI_IDLE;
         IO_OUT     <= 8'h00;
      end else begin
         state_q  <= state_d;
         mreq_q   <= MREQ;
         iorq_q   <= IORQ;
         rd_cap_q <= rd_cap_d;
         WAIT     <= wait_d;
         SRAM_CS  <= cs_d;
         SRAM_WE  <= we_d;
         DI       <= di_d;
         IO_OUT   <= io_out_d;
         if (latch_en) begin
            addr_l <= ADDR;
            do_l   <= DO;
            wr_l   <= WR;
            m1_l   <= M1;
         end
         if (cs_d) begin
            SRAM_ADDR  <= cur_addr;
            SRAM_WDATA <= cur_do;
         end
      end
   end

endmodule

// File: tb/tb_z80_mem_ctrl.sv
// tb/tb_z80_mem_ctrl.sv - self-checking bench for z80_mem_ctrl with two parameterisations
module tb_z80_mem_ctrl;

   localparam int         W0 = 2;
   localparam int         W1 = 0;
   localparam logic [7:0] B0 = 8'h00;
   localparam logic [7:0] B1 = 8'h40;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [15:0] ADDR;
   logic [7:0]  DO;
   logic        WR, MREQ, IORQ, M1;
   logic [7:0]  IO_IN, INT_VEC;

   logic [7:0]  di_o  [2];
   logic        wait_o[2];
   logic [15:0] sa_o  [2];
   logic [7:0]  swd_o [2];
   logic        cs_o  [2];
   logic        we_o  [2];
   logic [7:0]  io_o  [2];
   logic [7:0]  srd0, srd1;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   z80_mem_ctrl #(.WAIT_CYCLES(W0), .IO_BASE(B0)) dut0 (
      .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DO(DO), .DI(di_o[0]),
      .WR(WR), .MREQ(MREQ), .IORQ(IORQ), .M1(M1), .WAIT(wait_o[0]),
      .SRAM_ADDR(sa_o[0]), .SRAM_WDATA(swd_o[0]), .SRAM_RDATA(srd0),
      .SRAM_CS(cs_o[0]), .SRAM_WE(we_o[0]), .IO_IN(IO_IN), .IO_OUT(io_o[0]),
      .INT_VEC(INT_VEC)
   );

   z80_mem_ctrl #(.WAIT_CYCLES(W1), .IO_BASE(B1)) dut1 (
      .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DO(DO), .DI(di_o[1]),
      .WR(WR), .MREQ(MREQ), .IORQ(IORQ), .M1(M1), .WAIT(wait_o[1]),
      .SRAM_ADDR(sa_o[1]), .SRAM_WDATA(swd_o[1]), .SRAM_RDATA(srd1),
      .SRAM_CS(cs_o[1]), .SRAM_WE(we_o[1]), .IO_IN(IO_IN), .IO_OUT(io_o[1]),
      .INT_VEC(INT_VEC)
   );

   function automatic logic [7:0] fill(input logic [15:0] a);
      return a[15:8] ^ a[7:0] ^ 8'h5A;
   endfunction

   // Synchronous SRAM models: read data appears the cycle after the chip select.
   logic [7:0] mem0 [0:65535];
   bit         wv0  [0:65535];
   logic [7:0] mem1 [0:65535];
   bit         wv1  [0:65535];

   always @(posedge CLK) begin
      if (cs_o[0]) begin
         if (we_o[0]) begin
            mem0[sa_o[0]] <= swd_o[0];
            wv0[sa_o[0]]  <= 1'b1;
         end else
            srd0 <= wv0[sa_o[0]] ? mem0[sa_o[0]] : fill(sa_o[0]);
      end
      if (cs_o[1]) begin
         if (we_o[1]) begin
            mem1[sa_o[1]] <= swd_o[1];
            wv1[sa_o[1]]  <= 1'b1;
         end else
            srd1 <= wv1[sa_o[1]] ? mem1[sa_o[1]] : fill(sa_o[1]);
      end
   end

   int          wcnt[2];
   int          ccnt[2];
   logic [15:0] la  [2];
   logic        lwe [2];
   logic [7:0]  lwd [2];

   always @(negedge CLK) begin
      for (int i = 0; i < 2; i++) begin
         if (wait_o[i]) wcnt[i] <= wcnt[i] + 1;
         if (cs_o[i]) begin
            ccnt[i] <= ccnt[i] + 1;
            la[i]   <= sa_o[i];
            lwe[i]  <= we_o[i];
            lwd[i]  <= swd_o[i];
         end
      end
   end

   // Reference model: memory contents and each instance's output port.
   logic [7:0] ref_mem [int];
   logic [7:0] ref_io  [2];

   function automatic logic [7:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : fill(a);
   endfunction

   function automatic int wait_of(input int i);
      return (i == 0) ? W0 : W1;
   endfunction

   function automatic logic [7:0] base_of(input int i);
      return (i == 0) ? B0 : B1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // kind: 0 mem read, 1 mem write, 2 io read, 3 io write, 4 int ack, 5 MREQ+IORQ together
   task automatic run(input int kind, input logic [15:0] a, input logic [7:0] d, input int hold);
      int         w_s[2];
      int         c_s[2];
      logic       is_mem, is_wr;
      logic [7:0] exp_di;
      is_mem = (kind == 0) || (kind == 1) || (kind == 5);
      is_wr  = (kind == 1) || (kind == 3);
      for (int i = 0; i < 2; i++) begin
         w_s[i] = wcnt[i];
         c_s[i] = ccnt[i];
      end
      ADDR = a;
      DO   = d;
      WR   = is_wr;
      MREQ = is_mem;
      IORQ = (kind >= 2);
      M1   = (kind == 4);
      repeat (hold) tick();
      @(negedge CLK);
      if (!is_wr) begin
         for (int i = 0; i < 2; i++) begin
            if (is_mem)
               exp_di = ref_rd(a);
            else if (kind == 4)
               exp_di = INT_VEC;
            else
               exp_di = (a[7:0] == base_of(i)) ? IO_IN : 8'hFF;
            chk($sformatf("di_k%0d_u%0d", kind, i), 32'(di_o[i]), 32'(exp_di));
         end
      end
      MREQ = 1'b0;
      IORQ = 1'b0;
      M1   = 1'b0;
      WR   = 1'b0;
      repeat (8) tick();
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("wait_len_k%0d_u%0d", kind, i), 32'(wcnt[i] - w_s[i]),
             32'(is_mem ? wait_of(i) + 1 : 1));
         chk($sformatf("cs_pulses_k%0d_u%0d", kind, i), 32'(ccnt[i] - c_s[i]),
             32'(is_mem ? 1 : 0));
         if (is_mem) begin
            chk($sformatf("sram_addr_k%0d_u%0d", kind, i), 32'(la[i]), 32'(a));
            chk($sformatf("sram_we_k%0d_u%0d", kind, i), 32'(lwe[i]), 32'(is_wr));
            if (is_wr)
               chk($sformatf("sram_wdata_u%0d", i), 32'(lwd[i]), 32'(d));
         end
         if (kind == 3 && a[7:0] == base_of(i))
            ref_io[i] = d;
         chk($sformatf("io_out_k%0d_u%0d", kind, i), 32'(io_o[i]), 32'(ref_io[i]));
      end
      if (kind == 1)
         ref_mem[int'(a)] = d;
   endtask

   int          k;
   int          sel;
   logic [15:0] ra;
   logic [7:0]  lo;

   initial begin
      RESET   = 1'b0;
      ADDR    = '0;
      DO      = '0;
      WR      = 1'b0;
      MREQ    = 1'b0;
      IORQ    = 1'b0;
      M1      = 1'b0;
      IO_IN   = 8'h6B;
      INT_VEC = 8'h00;
      ref_io[0] = 8'h00;
      ref_io[1] = 8'h00;
      repeat (3) tick();
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_wait_u%0d", i), 32'(wait_o[i]), 32'd0);
         chk($sformatf("rst_cs_u%0d", i), 32'(cs_o[i]), 32'd0);
         chk($sformatf("rst_we_u%0d", i), 32'(we_o[i]), 32'd0);
         chk($sformatf("rst_saddr_u%0d", i), 32'(sa_o[i]), 32'h0000);
         chk($sformatf("rst_swdata_u%0d", i), 32'(swd_o[i]), 32'h00);
         chk($sformatf("rst_di_u%0d", i), 32'(di_o[i]), 32'hFF);
         chk($sformatf("rst_io_out_u%0d", i), 32'(io_o[i]), 32'h00);
      end
      tick();
      RESET = 1'b1;
      tick();

      run(1, 16'h1234, 8'hA5, 2);
      run(0, 16'h1234, 8'h00, 8);
      run(1, 16'hFFFF, 8'h3C, 1);
      run(0, 16'hFFFF, 8'h00, 8);
      run(3, 16'h1200, 8'h81, 3);
      run(2, 16'h0055, 8'h00, 8);
      INT_VEC = 8'hE7;
      run(4, 16'h0038, 8'h00, 8);
      run(5, 16'h1234, 8'h00, 8);

      // Reset in the middle of a wait-stated read, strobe still held through release.
      ADDR = 16'h1003;
      DO   = 8'h00;
      WR   = 1'b0;
      MREQ = 1'b1;
      tick();
      tick();
      chk("mid_cycle_wait_u0", 32'(wait_o[0]), 32'd1);
      RESET = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("async_rst_wait_u%0d", i), 32'(wait_o[i]), 32'd0);
         chk($sformatf("async_rst_cs_u%0d", i), 32'(cs_o[i]), 32'd0);
         chk($sformatf("async_rst_di_u%0d", i), 32'(di_o[i]), 32'hFF);
      end
      tick();
      RESET = 1'b1;
      ref_io[0] = 8'h00;
      ref_io[1] = 8'h00;
      run(0, 16'h1003, 8'h00, 8);

      for (int n = 0; n < 40; n++) begin
         k       = $urandom_range(0, 5);
         IO_IN   = 8'($urandom);
         INT_VEC = 8'($urandom);
         if (k >= 2 && k <= 4) begin
            sel = $urandom_range(0, 2);
            lo  = (sel == 0) ? B0 : (sel == 1) ? B1 : 8'($urandom);
            ra  = {8'($urandom), lo};
         end else begin
            ra = 16'h1000 + 16'($urandom_range(0, 7));
         end
         run(k, ra, 8'($urandom), (k == 1 || k == 3) ? $urandom_range(1, 8) : 8);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
